// File: rtl/mat_mul_driver_if.sv
// Bundle between the mat_mul_driver sequencer and its neighbours: the
// element stream in, the multiplier request/result ports, and the result
// stream out. The slave modport is the sequencer's view.
//
// Handshake semantics: an element moves on a rising clk edge exactly when
// its valid and ready are both high in the cycle before that edge; valid
// never waits for ready. On the multiplier side, m_dv is the transfer
// itself, a one-cycle pulse that is already qualified by m_ready.
// m_c_dv is a one-cycle strobe that marks m_C as valid.
interface mat_mul_driver_if #(
    parameter int DATAWIDTH = 18
);
    logic [DATAWIDTH-1:0]             s_data;
    logic                             s_valid;
    logic                             s_ready;
    logic [3:0][3:0][DATAWIDTH-1:0]   m_A;
    logic [3:0][3:0][DATAWIDTH-1:0]   m_B;
    logic                             m_dv;
    logic                             m_ready;
    logic [3:0][3:0][DATAWIDTH-1:0]   m_C;
    logic                             m_c_dv;
    logic [DATAWIDTH-1:0]             o_data;
    logic                             o_valid;
    logic                             o_ready;
    logic                             o_last;
    logic                             busy;
    logic [1:0]                       dbg_state;

    modport slave (
        input  s_data, s_valid, m_ready, m_C, m_c_dv, o_ready,
        output s_ready, m_A, m_B, m_dv, o_data, o_valid, o_last, busy, dbg_state
    );

    modport master (
        output s_data, s_valid, m_ready, m_C, m_c_dv, o_ready,
        input  s_ready, m_A, m_B, m_dv, o_data, o_valid, o_last, busy, dbg_state
    );
endinterface

// File: rtl/mat_mul_driver.sv
// Initiator-side sequencer for the 4x4 fixed-point matrix multiplier.
// It loads A then B from a serial row-major stream, issues one multiply,
// captures C, and then streams C out row-major with backpressure.
// Values pass through bit-exact; this block does no arithmetic on data.
module mat_mul_driver #(
    parameter int DATAWIDTH = 18
) (
    input  logic              clk,
    input  logic              rstn,
    mat_mul_driver_if.slave   bus
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [4:0]                      r_cnt;
    logic [3:0][3:0][DATAWIDTH-1:0]  r_a;
    logic [3:0][3:0][DATAWIDTH-1:0]  r_b;
    logic [3:0][3:0][DATAWIDTH-1:0]  r_c;

    logic w_load_acc;
    logic w_drain_acc;
    logic w_s_ready;
    logic w_o_valid;
    logic w_o_last;
    logic w_busy;
    logic w_m_dv;

    // An accept is only possible in the state that owns that stream.
    assign w_load_acc  = (r_state == LOAD)  && bus.s_valid;
    assign w_drain_acc = (r_state == DRAIN) && bus.o_ready;

    // Next-state and output decode. Flags come from the state register only.
    // m_dv is the single output that also follows m_ready combinationally.
    always_comb begin
        w_next    = r_state;
        w_s_ready = 1'b0;
        w_o_valid = 1'b0;
        w_o_last  = 1'b0;
        w_busy    = 1'b1;
        w_m_dv    = 1'b0;
        case (r_state)
            LOAD: begin
                w_s_ready = 1'b1;
                w_busy    = 1'b0;
                if (w_load_acc && (r_cnt == 5'd31)) w_next = ISSUE;
            end
            ISSUE: begin
                w_m_dv = bus.m_ready;
                if (bus.m_ready) w_next = WAIT;
            end
            WAIT: begin
                if (bus.m_c_dv) w_next = DRAIN;
            end
            DRAIN: begin
                w_o_valid = 1'b1;
                w_o_last  = (r_cnt == 5'd15);
                if (w_drain_acc && (r_cnt == 5'd15)) w_next = LOAD;
            end
            default: w_next = LOAD;
        endcase
    end

    // State register and element counter. The counter clears on every state change.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= LOAD;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= 5'd0;
            end else if (w_load_acc || w_drain_acc) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // A/B storage. cnt[4] selects B and the low bits give the row and column.
    // These registers drive the multiplier directly, so they hold after LOAD.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_load_acc) begin
            if (r_cnt[4]) r_b[r_cnt[3:2]][r_cnt[1:0]] <= bus.s_data;
            else          r_a[r_cnt[3:2]][r_cnt[1:0]] <= bus.s_data;
        end
    end

    // C capture happens only in WAIT, so stray result strobes are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_c <= '0;
        end else if ((r_state == WAIT) && bus.m_c_dv) begin
            r_c <= bus.m_C;
        end
    end

    assign bus.s_ready   = w_s_ready;
    assign bus.o_valid   = w_o_valid;
    assign bus.o_last    = w_o_last;
    assign bus.busy      = w_busy;
    assign bus.m_dv      = w_m_dv;
    assign bus.m_A       = r_a;
    assign bus.m_B       = r_b;
    assign bus.o_data    = (r_state == DRAIN) ? r_c[r_cnt[3:2]][r_cnt[1:0]] : '0;
    assign bus.dbg_state = r_state;

endmodule
